branch_sequencer: RTL



---
 rtl/cpu_pkg.sv | 17 +
 rtl/branch_decode.sv | 22 ++
 rtl/branch_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings and sequencer state type for the single-cycle datapath control.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

    localparam logic [2:0] OP_BR      = 3'b110;
    localparam logic [2:0] OP_SYS     = 3'b111;
    localparam logic [5:0] HALT_FIELD = 6'h3F;
    localparam int         CPSR_Z     = 1;
    localparam int         CPSR_DIR   = 0;

endpackage

// File: rtl/branch_decode.sv
// Combinational branch/halt decode of a 9-bit instruction against the status flags.
module branch_decode
    import cpu_pkg::*;
(
    input  logic [8:0] instr,
    input  logic [7:0] cpsr,
    output logic       is_br,
    output logic       br_taken,
    output logic       is_halt,
    output logic [4:0] offset
);

    // Direction and the remaining flags belong to the PC unit.
    logic unused_cpsr;
    assign unused_cpsr = ^{cpsr[7:2], cpsr[CPSR_DIR]};

    assign is_br    = (instr[8:6] == OP_BR);
    assign br_taken = is_br && (!instr[5] || cpsr[CPSR_Z]);
    assign is_halt  = (instr[8:6] == OP_SYS) && (instr[5:0] == HALT_FIELD);
    assign offset   = instr[4:0];

endmodule

// File: rtl/branch_sequencer.sv
// Run sequencer for the PC update unit: init/run/halt control, cycle counting,
// timeout and self-loop guards.
//
//   state  | meaning
//   IDLE   | after reset, PC held, waiting for start
//   INIT   | init asserted for INIT_CYCLES cycles to zero the PC
//   RUN    | executing; branch/Target/halt decoded from instr/cpsr
//   HALTED | run finished, done high, counter and flags held
module branch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MAX_CYCLES  = 32'h0000_FFFF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [8:0]       instr,
    input  logic [7:0]       cpsr,
    output logic             init,
    output logic             branch,
    output logic [4:0]       Target,
    output logic             halt,
    output logic             done,
    output logic             timeout,
    output logic             selfloop,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned       INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

    seq_state_t        state, state_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic              start_run;
    logic              loop_hit;
    logic              tmo_hit;

    logic       is_br, br_taken, is_halt;
    logic [4:0] offset;

    branch_decode u_decode (
        .instr    (instr),
        .cpsr     (cpsr),
        .is_br    (is_br),
        .br_taken (br_taken),
        .is_halt  (is_halt),
        .offset   (offset)
    );

    always_comb begin
        state_nxt = state;
        init      = 1'b0;
        branch    = 1'b0;
        Target    = 5'd0;
        halt      = 1'b1;
        start_run = 1'b0;
        loop_hit  = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nxt = INIT;
                    start_run = 1'b1;
                end
            end
            INIT: begin
                init = 1'b1;
                halt = 1'b0;
                if (init_cnt == '0) state_nxt = RUN;
            end
            RUN: begin
                tmo_hit  = (cycle_count == CNT_LAST);
                loop_hit = br_taken && (offset == 5'd0);
                halt     = is_halt || loop_hit || tmo_hit;
                // A halting cycle never also redirects the PC.
                branch   = br_taken && !halt;
                Target   = is_br ? offset : 5'd0;
                if (halt) state_nxt = HALTED;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            init_cnt    <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            selfloop    <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == HALTED);
            if (start_run) begin
                init_cnt    <= INIT_LOAD;
                cycle_count <= '0;
                timeout     <= 1'b0;
                selfloop    <= 1'b0;
            end else begin
                if (state == INIT && init_cnt != '0) init_cnt <= init_cnt - 1'b1;
                if (state == RUN) begin
                    if (cycle_count != CNT_SAT) cycle_count <= cycle_count + 1'b1;
                    if (tmo_hit)  timeout  <= 1'b1;
                    if (loop_hit) selfloop <= 1'b1;
                end
            end
        end
    end

endmodule
